// File: rtl/const_imm_fetch.sv
// const_imm_fetch
// Fetches and assembles the immediate operand of the WebAssembly const
// instructions (i32/i64/f32/f64.const) from a synchronous byte ROM.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   start          request, sampled in IDLE only
//   opcode, pc_in  const opcode and address of first immediate byte
//   rom_addr       registered ROM byte address
//   rom_data       ROM byte for the address presented on the previous edge
//   busy, done     busy from accepted start until done; one-cycle done pulse
//   value          assembled 64-bit immediate (held until next completion)
//   pc_out         pc_in + bytes consumed (wraps)
//   trap           0 none, 1 bad opcode, 2 overlong LEB128
//
// state | meaning
// IDLE  | waiting for start
// PRIME | first ROM address presented, waiting for the ROM's read latency
// FETCH | one immediate byte consumed per cycle
module const_imm_fetch #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic                  busy,
  output logic                  done,
  output logic [63:0]           value,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [2:0]            trap
);

  typedef enum logic [1:0] {IDLE, PRIME, FETCH} state_t;

  localparam logic [7:0] OP_I32 = 8'h41;
  localparam logic [7:0] OP_I64 = 8'h42;
  localparam logic [7:0] OP_F32 = 8'h43;
  localparam logic [7:0] OP_F64 = 8'h44;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_d, pc_out_d;
  logic                  busy_d, done_d;
  logic [63:0]           value_d, acc, acc_d;
  logic [2:0]            trap_d;
  logic [3:0]            cnt, cnt_d;
  logic [7:0]            op, op_d;

  // Byte-lane shift amounts for the current byte index.
  logic [5:0]  fix_sh;
  logic [6:0]  leb_sh, sext_sh;
  logic [63:0] sext_mask, leb_val;
  logic        is_leb, is_64, fix_last, leb_last;

  assign is_leb   = (op == OP_I32) || (op == OP_I64);
  assign is_64    = (op == OP_I64) || (op == OP_F64);
  assign fix_last = is_64 ? (cnt == 4'd7) : (cnt == 4'd3);
  assign leb_last = is_64 ? (cnt == 4'd9) : (cnt == 4'd4);
  assign fix_sh   = {cnt[2:0], 3'b000};
  assign leb_sh   = {3'b000, cnt} * 7'd7;
  assign sext_sh  = leb_sh + 7'd7;
  // Shifts of 64 or more yield zero, so a full-width final byte gets no extension.
  assign sext_mask = ~64'h0 << sext_sh;

  always_comb begin
    state_d    = state;
    rom_addr_d = rom_addr;
    busy_d     = busy;
    done_d     = 1'b0;
    value_d    = value;
    pc_out_d   = pc_out;
    trap_d     = trap;
    cnt_d      = cnt;
    acc_d      = acc;
    op_d       = op;
    leb_val    = 64'h0;
    case (state)
      IDLE: begin
        if (start) begin
          op_d   = opcode;
          acc_d  = 64'h0;
          cnt_d  = 4'd0;
          trap_d = 3'd0;
          if (opcode >= OP_I32 && opcode <= OP_F64) begin
            rom_addr_d = pc_in;
            busy_d     = 1'b1;
            state_d    = PRIME;
          end else begin
            trap_d = 3'd1;
            done_d = 1'b1;
          end
        end
      end
      PRIME: begin
        rom_addr_d = rom_addr + 1'b1;
        state_d    = FETCH;
      end
      FETCH: begin
        rom_addr_d = rom_addr + 1'b1;
        cnt_d      = cnt + 4'd1;
        if (is_leb) begin
          acc_d   = acc | ({57'h0, rom_data[6:0]} << leb_sh);
          leb_val = acc_d | (rom_data[6] ? sext_mask : 64'h0);
          if (!rom_data[7]) begin
            value_d = is_64 ? leb_val : {32'h0, leb_val[31:0]};
            state_d = IDLE;
          end else if (leb_last) begin
            trap_d  = 3'd2;
            state_d = IDLE;
          end
        end else begin
          acc_d = acc | ({56'h0, rom_data} << fix_sh);
          if (fix_last) begin
            value_d = acc_d;
            state_d = IDLE;
          end
        end
        // rom_addr already points one past the consumed byte, i.e. pc_in + N.
        if (state_d == IDLE) begin
          busy_d   = 1'b0;
          done_d   = 1'b1;
          pc_out_d = rom_addr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      value    <= 64'h0;
      pc_out   <= '0;
      trap     <= 3'd0;
      cnt      <= 4'd0;
      acc      <= 64'h0;
      op       <= 8'h0;
    end else begin
      state    <= state_d;
      rom_addr <= rom_addr_d;
      busy     <= busy_d;
      done     <= done_d;
      value    <= value_d;
      pc_out   <= pc_out_d;
      trap     <= trap_d;
      cnt      <= cnt_d;
      acc      <= acc_d;
      op       <= op_d;
    end
  end

endmodule

// File: tb/tb_const_imm_fetch.sv
// Testbench for const_imm_fetch: directed cases plus randomized operations,
// checked against a value-level reference of the const immediate encodings.
module tb_const_imm_fetch;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  opcode, pc_in, rom_addr, rom_data, pc_out;
  logic        busy, done;
  logic [63:0] value;
  logic [2:0]  trap;

  logic [7:0] rom [256];
  int n_vec = 0;
  int n_err = 0;

  const_imm_fetch #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .pc_in(pc_in),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .done(done),
    .value(value), .pc_out(pc_out), .trap(trap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value-level reference: fixed-width little-endian, or signed LEB128
  // interpreted as a two's-complement number truncated to the target width.
  task automatic ref_model(input logic [7:0] op, input logic [7:0] pc,
                           output logic [63:0] v, output int n, output logic [2:0] t);
    logic [127:0] acc;
    logic [7:0]   b;
    int           maxb;
    v = 64'h0; n = 0; t = 3'd0; acc = 128'h0;
    if (op == 8'h43 || op == 8'h44) begin
      n = (op == 8'h43) ? 4 : 8;
      for (int i = 0; i < n; i++)
        acc = acc + (128'(rom[8'(pc + i)]) << (8 * i));
      v = acc[63:0];
    end else if (op == 8'h41 || op == 8'h42) begin
      maxb = (op == 8'h41) ? 5 : 10;
      t = 3'd2;
      n = maxb;
      for (int i = 0; i < maxb; i++) begin
        b = rom[8'(pc + i)];
        acc = acc + 128'(b[6:0]) * (128'(1) << (7 * i));
        if (!b[7]) begin
          n = i + 1;
          t = 3'd0;
          if (b[6]) acc = acc - (128'(1) << (7 * n));
          break;
        end
      end
      if (t == 3'd0) v = (op == 8'h41) ? {32'h0, acc[31:0]} : acc[63:0];
    end else begin
      t = 3'd1;
    end
  endtask

  task automatic load(input logic [7:0] pc, input logic [79:0] bytes_le, input int n);
    for (int k = 0; k < n; k++) rom[8'(pc + k)] = bytes_le[8*k +: 8];
  endtask

  // Starts an operation and waits for done; returns in the done cycle so a
  // following call exercises back-to-back acceptance.
  task automatic run_op(input logic [7:0] op, input logic [7:0] pc, input bit noise);
    logic [63:0] ev;
    int          en, lat, exp_lat;
    logic [2:0]  et;
    logic [7:0]  ra0;
    ref_model(op, pc, ev, en, et);
    ra0    = rom_addr;
    opcode = op;
    pc_in  = pc;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      if (noise) begin
        start  = 1'b1;
        opcode = 8'h45;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    exp_lat = (et == 3'd1) ? 1 : en + 2;
    check("latency", 64'(lat), 64'(exp_lat));
    check("busy_at_done", 64'(busy), 64'h0);
    check("trap", 64'(trap), 64'(et));
    if (et == 3'd0) check("value", value, ev);
    if (et != 3'd1) check("pc_out", 64'(pc_out), 64'(8'(pc + en)));
    else            check("rom_addr_hold", 64'(rom_addr), 64'(ra0));
  endtask

  logic [7:0] rop, rpc;

  initial begin
    for (int k = 0; k < 256; k++) rom[k] = 8'h00;
    reset = 1'b1; start = 1'b0; opcode = 8'h00; pc_in = 8'h00;
    #1;
    check("rst_rom_addr", 64'(rom_addr), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_value", value, 64'h0);
    check("rst_pc_out", 64'(pc_out), 64'h0);
    check("rst_trap", 64'(trap), 64'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    load(8'h04, 80'hC0000000, 4);
    run_op(8'h43, 8'h04, 1'b0);
    check("f32_const", value, 64'h00000000_C0000000);
    check("f32_pc", 64'(pc_out), 64'h08);
    load(8'h10, 80'h7F, 1);
    run_op(8'h41, 8'h10, 1'b0);
    check("i32_neg1", value, 64'h00000000_FFFFFFFF);
    load(8'h20, 80'h268EE5, 3);
    run_op(8'h41, 8'h20, 1'b0);
    check("i32_98765", value, 64'h00000000_00098765);
    load(8'h30, 80'h78BBC0, 3);
    run_op(8'h42, 8'h30, 1'b0);
    check("i64_neg", value, 64'hFFFFFFFF_FFFE1DC0);
    load(8'h40, 80'h3FF0000000000000, 8);
    run_op(8'h44, 8'h40, 1'b0);
    check("f64_one", value, 64'h3FF00000_00000000);
    run_op(8'h45, 8'h50, 1'b0);
    check("bad_op", 64'(trap), 64'h1);
    load(8'h60, 80'h8080808080, 5);
    run_op(8'h41, 8'h60, 1'b0);
    check("i32_overlong", 64'(trap), 64'h2);
    load(8'h70, 80'h80808080808080808080, 10);
    run_op(8'h42, 8'h70, 1'b1);
    load(8'hFE, 80'h44332211, 4);
    run_op(8'h43, 8'hFE, 1'b0);
    check("wrap_pc", 64'(pc_out), 64'h02);
    check("wrap_val", value, 64'h00000000_44332211);
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'h0);

    for (int it = 0; it < 60; it++) begin
      rpc = 8'($urandom);
      case ($urandom_range(4))
        0: rop = 8'h41;
        1: rop = 8'h42;
        2: rop = 8'h43;
        3: rop = 8'h44;
        default: begin
          rop = 8'($urandom);
          if (rop >= 8'h41 && rop <= 8'h44) rop = 8'h00;
        end
      endcase
      for (int k = 0; k < 10; k++) begin
        rom[8'(rpc + k)] = 8'($urandom);
        if ($urandom_range(9) < 4) rom[8'(rpc + k)][7] = 1'b0;
      end
      run_op(rop, rpc, 1'($urandom_range(1)));
      if ($urandom_range(1) == 1) begin
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'h0);
      end
    end

    // Reset during an f64 fetch.
    load(8'h80, 80'h1122334455667788, 8);
    opcode = 8'h44; pc_in = 8'h80; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_rom_addr", 64'(rom_addr), 64'h0);
    check("mid_rst_busy", 64'(busy), 64'h0);
    check("mid_rst_done", 64'(done), 64'h0);
    check("mid_rst_value", value, 64'h0);
    check("mid_rst_pc_out", 64'(pc_out), 64'h0);
    check("mid_rst_trap", 64'(trap), 64'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      check("no_done_after_rst", 64'(done), 64'h0);
    end
    run_op(8'h44, 8'h80, 1'b0);
    check("post_rst_f64", value, 64'h11223344_55667788);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
